// File: rtl/cpu_sequencer.sv
// Eight-phase VeRISC instruction sequencer: a phase counter plus a halt latch,
// with every strobe decoded combinationally from (phase, opcode, zero).
//
// state      | meaning
// -----------+------------------------------------------------------
// INST_ADDR  | PC drives the address bus
// INST_FETCH | memory read of the instruction word
// INST_LOAD  | instruction register captures the word
// IDLE       | IR stable, opcode valid from here on
// OP_ADDR    | PC increment, HLT detected here
// OP_FETCH   | operand read for ALU-class opcodes
// ALU_OP     | ALU result forming, SKZ skip, JMP load, STO drives bus
// STORE      | accumulator load, JMP load, STO write strobe
// (halted)   | frozen at OP_ADDR after HLT, cleared only by reset
module cpu_sequencer #(
  parameter bit STALL_ON_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       ld_ac,
  output logic       wr,
  output logic       data_e,
  output logic       halt,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  phase_t state;
  logic   halted;
  logic   stop_now;
  logic   alu_op;

  assign alu_op   = (opcode == OP_ADD) || (opcode == OP_AND) ||
                    (opcode == OP_XOR) || (opcode == OP_LDA);
  assign stop_now = STALL_ON_HALT && (state == OP_ADDR) && (opcode == OP_HLT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= INST_ADDR;
    end else if (!halted && !stop_now) begin
      state <= phase_t'(state + 3'd1);
    end
  end

  generate
    if (STALL_ON_HALT) begin : g_halt
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          halted <= 1'b0;
        end else if (stop_now) begin
          halted <= 1'b1;
        end
      end
    end else begin : g_no_halt
      assign halted = 1'b0;
    end
  endgenerate

  // Strobes are pure decodes so an async reset kills wr/data_e immediately.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    if (halted) begin
      halt = 1'b1;
    end else begin
      unique case (state)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = (opcode == OP_HLT);
        end
        OP_FETCH: begin
          rd = alu_op;
        end
        ALU_OP: begin
          rd     = alu_op;
          inc_pc = (opcode == OP_SKZ) && zero;
          ld_pc  = (opcode == OP_JMP);
          data_e = (opcode == OP_STO);
        end
        STORE: begin
          rd     = alu_op;
          ld_ac  = alu_op;
          ld_pc  = (opcode == OP_JMP);
          wr     = (opcode == OP_STO);
          data_e = (opcode == OP_STO);
        end
      endcase
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer (stalling and non-stalling halt builds).
module tb_cpu_sequencer;

  logic       clk;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;

  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
  logic [2:0] phase;
  logic       sel0, rd0, ld_ir0, inc_pc0, ld_pc0, ld_ac0, wr0, data_e0, halt0;
  logic [2:0] phase0;

  logic [8:0] outs, outs0;
  int compared = 0;
  int mismatched = 0;
  int inc_count;

  localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, AND_ = 3'd3,
                         XOR_ = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;

  // Output vector order: sel rd ld_ir inc_pc ld_pc ld_ac wr data_e halt
  localparam logic [8:0] V_P0   = 9'b100000000;
  localparam logic [8:0] V_P1   = 9'b110000000;
  localparam logic [8:0] V_P23  = 9'b111000000;
  localparam logic [8:0] V_INC  = 9'b000100000;
  localparam logic [8:0] V_NONE = 9'b000000000;
  localparam logic [8:0] V_RD   = 9'b010000000;
  localparam logic [8:0] V_LDAC = 9'b010001000;
  localparam logic [8:0] V_DE   = 9'b000000010;
  localparam logic [8:0] V_WRDE = 9'b000000110;
  localparam logic [8:0] V_LDPC = 9'b000010000;
  localparam logic [8:0] V_HLT4 = 9'b000100001;
  localparam logic [8:0] V_HALT = 9'b000000001;

  assign outs  = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};
  assign outs0 = {sel0, rd0, ld_ir0, inc_pc0, ld_pc0, ld_ac0, wr0, data_e0, halt0};

  cpu_sequencer #(.STALL_ON_HALT(1'b1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .ld_pc(ld_pc),
    .ld_ac(ld_ac), .wr(wr), .data_e(data_e), .halt(halt), .phase(phase)
  );

  cpu_sequencer #(.STALL_ON_HALT(1'b0)) dut_nostall (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .sel(sel0), .rd(rd0), .ld_ir(ld_ir0), .inc_pc(inc_pc0), .ld_pc(ld_pc0),
    .ld_ac(ld_ac0), .wr(wr0), .data_e(data_e0), .halt(halt0), .phase(phase0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts at a falling edge with phase 0; checks all 8 phases, ends at phase 0.
  task automatic run_instr(input string tag, input logic [2:0] op, input logic z,
                           input logic [8:0] e4, input logic [8:0] e5,
                           input logic [8:0] e6, input logic [8:0] e7);
    logic [8:0] ev [8];
    ev[0] = V_P0; ev[1] = V_P1; ev[2] = V_P23; ev[3] = V_P23;
    ev[4] = e4;   ev[5] = e5;   ev[6] = e6;    ev[7] = e7;
    opcode = op;
    zero   = z;
    inc_count = 0;
    for (int p = 0; p < 8; p++) begin
      #1;
      chk($sformatf("%s_phase%0d", tag, p), {29'd0, phase}, p);
      chk($sformatf("%s_outs_p%0d", tag, p), {23'd0, outs}, {23'd0, ev[p]});
      if (inc_pc) inc_count++;
      @(negedge clk);
    end
  endtask

  initial begin
    rst    = 1'b0;
    opcode = ADD;
    zero   = 1'b0;
    #2;
    chk("reset_phase", {29'd0, phase}, 0);
    chk("reset_outs", {23'd0, outs}, {23'd0, V_P0});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    run_instr("add", ADD, 1'b0, V_INC, V_RD, V_RD, V_LDAC);
    chk("add_inc_count", inc_count, 1);
    run_instr("and", AND_, 1'b1, V_INC, V_RD, V_RD, V_LDAC);
    run_instr("xor", XOR_, 1'b0, V_INC, V_RD, V_RD, V_LDAC);
    run_instr("lda", LDA, 1'b0, V_INC, V_RD, V_RD, V_LDAC);
    run_instr("sto", STO, 1'b0, V_INC, V_NONE, V_DE, V_WRDE);
    run_instr("skz_z1", SKZ, 1'b1, V_INC, V_NONE, V_INC, V_NONE);
    chk("skz_z1_inc_count", inc_count, 2);
    run_instr("skz_z0", SKZ, 1'b0, V_INC, V_NONE, V_NONE, V_NONE);
    chk("skz_z0_inc_count", inc_count, 1);
    run_instr("jmp", JMP, 1'b1, V_INC, V_NONE, V_LDPC, V_LDPC);
    chk("nostall_phase_sync", {29'd0, phase0}, 0);

    // HLT: walk phases 0..4, then the stalling build must freeze at 4.
    opcode = HLT;
    zero   = 1'b0;
    for (int p = 0; p < 4; p++) @(negedge clk);
    #1;
    chk("hlt_phase4", {29'd0, phase}, 4);
    chk("hlt_outs_p4", {23'd0, outs}, {23'd0, V_HLT4});
    chk("nostall_hlt_outs_p4", {23'd0, outs0}, {23'd0, V_HLT4});
    @(negedge clk);
    #1;
    chk("nostall_phase5", {29'd0, phase0}, 5);
    chk("nostall_outs_p5", {23'd0, outs0}, {23'd0, V_NONE});
    opcode = ADD;
    zero   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk($sformatf("halted_phase_c%0d", i), {29'd0, phase}, 4);
      chk($sformatf("halted_outs_c%0d", i), {23'd0, outs}, {23'd0, V_HALT});
      @(negedge clk);
    end

    rst = 1'b0;
    #1;
    chk("halt_reset_phase", {29'd0, phase}, 0);
    chk("halt_reset_outs", {23'd0, outs}, {23'd0, V_P0});
    @(negedge clk);
    rst = 1'b1;
    run_instr("post_halt_add", ADD, 1'b0, V_INC, V_RD, V_RD, V_LDAC);

    // Async reset in the middle of STO phase 7.
    opcode = STO;
    zero   = 1'b0;
    for (int p = 0; p < 7; p++) @(negedge clk);
    #1;
    chk("sto_mid_phase7", {29'd0, phase}, 7);
    chk("sto_mid_wr_de", {30'd0, wr, data_e}, 2'b11);
    #1;
    rst = 1'b0;
    #1;
    chk("async_rst_wr_de", {30'd0, wr, data_e}, 2'b00);
    chk("async_rst_phase", {29'd0, phase}, 0);
    chk("async_rst_outs", {23'd0, outs}, {23'd0, V_P0});
    @(negedge clk);
    rst = 1'b1;
    run_instr("post_rst_jmp", JMP, 1'b0, V_INC, V_NONE, V_LDPC, V_LDPC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Eight-phase instruction sequencer for the VeRISC core. It sits directly upstream of the program counter and drives that counter's load/enab inputs (inc_pc, ld_pc).
- Also drives the memory, instruction-register, accumulator and address-mux strobes.
- Decodes the 3-bit opcode held in the instruction register, plus the ALU zero flag.
- One instruction completes every 8 clocks.

Parameters:
- STALL_ON_HALT, 1: 1 = the HLT opcode freezes the sequencer in a HALTED state until reset; 0 = halt is a one-phase pulse and sequencing continues.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- opcode  input  3  instruction-register opcode field.
- zero  input  1  accumulator-is-zero flag from the ALU.
- sel  output  1  address mux select (1 = PC, 0 = IR operand).
- rd  output  1  memory read enable.
- ld_ir  output  1  instruction register load.
- inc_pc  output  1  to counter enab.
- ld_pc  output  1  to counter load.
- ld_ac  output  1  accumulator load.
- wr  output  1  memory write strobe.
- data_e  output  1  accumulator-to-data-bus drive enable.
- halt  output  1  halt indicator.
- phase  output  3  current phase, for debug/trace.

Behaviour:
- State: a 3-bit phase register plus a halted flag (halted exists only when STALL_ON_HALT=1).
- Phase sequence: 0 INST_ADDR, 1 INST_FETCH, 2 INST_LOAD, 3 IDLE, 4 OP_ADDR, 5 OP_FETCH, 6 ALU_OP, 7 STORE. After 7 the phase wraps to 0. It advances by one every clock unless halted.
- Reset (rst=0, asynchronous): phase=0, halted=0.
  - All strobes are decoded from phase, so while reset is held the outputs read sel=1 and everything else 0.
  - Reset asserted mid-instruction aborts it immediately. No partial write survives, because wr is only a decode.
  - On rst release, the first rising edge moves the phase 0->1.
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- ALUOP = opcode is ADD, AND, XOR or LDA.
- Outputs are combinational decodes of (phase, opcode, zero). Zero latency relative to phase. Strobes not listed for a phase are 0.
  - Phase 0: sel.
  - Phase 1: sel, rd.
  - Phase 2: sel, rd, ld_ir.
  - Phase 3: sel, rd, ld_ir.
  - Phase 4: inc_pc; halt = (opcode==HLT).
  - Phase 5: rd = ALUOP.
  - Phase 6: rd = ALUOP; inc_pc = (opcode==SKZ && zero); ld_pc = (opcode==JMP); data_e = (opcode==STO).
  - Phase 7: rd = ALUOP; ld_ac = ALUOP; ld_pc = (opcode==JMP); wr = (opcode==STO); data_e = (opcode==STO).
- Simultaneous inc_pc and ld_pc never occur: the decode excludes it.
- Halt, STALL_ON_HALT=1:
  - At the phase-4 edge with opcode==HLT, halted is set and phase stays at 4.
  - While halted: halt=1, every other strobe is 0, phase reads 4, and opcode/zero are ignored.
  - Only reset clears halted.
  - The PC was already incremented in phase 4 on the halting cycle, so the PC points past the HLT instruction.
- Halt, STALL_ON_HALT=0: halt is high for the single phase-4 cycle and sequencing continues normally.
- opcode and zero are sampled only via the decode. Changes to opcode outside phases 4-7 have no effect on strobes in those phases. The IR holds opcode stable from phase 3 onward.
- zero is only consulted in phase 6.

Test Plan:
- Reset then free-run with opcode=ADD:
  - phase must go 0,1,...,7,0.
  - inc_pc high only in phase 4.
  - rd high in phases 1,2,3,5,6,7; ld_ac high only in phase 7; wr never high.
- opcode=STO:
  - data_e high in phases 6 and 7, wr high only in phase 7.
  - rd low in phases 5-7.
  - ld_ac never high.
- opcode=SKZ:
  - with zero=1: inc_pc high in phases 4 and 6, giving 2 counter increments per instruction.
  - with zero=0: inc_pc high in phase 4 only.
- opcode=JMP: ld_pc high in phases 6 and 7, inc_pc low in phases 6 and 7.
- opcode=HLT, STALL_ON_HALT=1:
  - after the phase-4 edge, halt stays 1 and phase stays 4 for 20 cycles, with all other strobes 0 even if opcode changes to ADD.
  - rst=0 pulse returns phase to 0 with halt=0.
- Reset asserted asynchronously mid-phase 7 with opcode=STO: wr and data_e drop immediately, before the next clk edge, and phase reads 0.
